// File: rtl/multiplicador_matrizes_param_if.sv
// Bus bundle for the parametrised matrix multiplier.
//
// Handshake: the master raises inicio together with a stable tamanho and
// operands; the slave samples them only while idle. An accepted request raises
// ocupado at the next edge. Completion is a one-cycle pronto pulse with ocupado
// dropping on the same edge. A rejected request (tamanho 0 or above N_MAX)
// gives a one-cycle erro pulse and leaves the slave idle. Requests made while
// ocupado is high are ignored.
interface multiplicador_matrizes_param_if #(
   parameter int N_MAX   = 5,
   parameter int LARGURA = 8
);
   localparam int TW = $clog2(N_MAX + 1);
   localparam int MW = N_MAX * N_MAX * LARGURA;

   logic          inicio;
   logic [TW-1:0] tamanho;
   logic [MW-1:0] matriz_a;
   logic [MW-1:0] matriz_b;
   logic [MW-1:0] matriz_result;
   logic          ocupado;
   logic          pronto;
   logic          erro;
   logic          overflow;

   modport master (
      output inicio, tamanho, matriz_a, matriz_b,
      input  matriz_result, ocupado, pronto, erro, overflow
   );

   modport slave (
      input  inicio, tamanho, matriz_a, matriz_b,
      output matriz_result, ocupado, pronto, erro, overflow
   );
endinterface

// File: rtl/multiplicador_matrizes_param.sv
// Signed matrix multiplier R = A x B for a runtime size up to N_MAX.
// Operands are latched at start; one result row is written per clock.
// Each element is narrowed to LARGURA bits (clamped or wrapped) and a sticky
// overflow flag records whether any element fell outside the signed range.
module multiplicador_matrizes_param #(
   parameter int N_MAX   = 5,
   parameter int LARGURA = 8,
   parameter int SATURAR = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   multiplicador_matrizes_param_if.slave bus,
   output logic                         o_dbg_estado
);
   localparam int TW = $clog2(N_MAX + 1);
   localparam int MW = N_MAX * N_MAX * LARGURA;
   localparam int RW = N_MAX * LARGURA;
   localparam int PW = 2 * LARGURA;
   localparam int AW = 2 * LARGURA + $clog2(N_MAX);

   // Signed range limits of one result element, at accumulator width.
   localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (LARGURA - 1)) - AW'(1);
   localparam logic signed [AW-1:0] MINV = ~MAXV;

   typedef enum logic {OCIOSO, CALCULA} estado_t;

   estado_t       r_estado;
   estado_t       w_prox;
   logic          w_aceita;
   logic          w_rejeita;
   logic          w_fim;

   logic [MW-1:0] r_a;
   logic [MW-1:0] r_b;
   logic [TW-1:0] r_tam;
   logic [TW-1:0] r_linha;
   logic [MW-1:0] r_result;
   logic          r_ocupado;
   logic          r_pronto;
   logic          r_erro;
   logic          r_overflow;

   logic [RW-1:0]         w_linha;
   logic                  w_ovf_linha;
   logic signed [LARGURA-1:0] w_ea;
   logic signed [LARGURA-1:0] w_eb;
   logic signed [PW-1:0]  w_prod;
   logic signed [AW-1:0]  w_acc;
   logic [LARGURA-1:0]    w_el;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_estado <= OCIOSO;
      else     r_estado <= w_prox;
   end

   // Next state and control strobes: accept/reject a start while idle, finish on last row.
   always_comb begin
      w_prox    = r_estado;
      w_aceita  = 1'b0;
      w_rejeita = 1'b0;
      w_fim     = 1'b0;
      case (r_estado)
         OCIOSO: begin
            if (bus.inicio) begin
               if (bus.tamanho != '0 && bus.tamanho <= TW'(N_MAX)) begin
                  w_aceita = 1'b1;
                  w_prox   = CALCULA;
               end else begin
                  w_rejeita = 1'b1;
               end
            end
         end
         CALCULA: begin
            if (r_linha == r_tam - TW'(1)) begin
               w_fim  = 1'b1;
               w_prox = OCIOSO;
            end
         end
         default: w_prox = OCIOSO;
      endcase
   end

   // One result row: dot products of row r_linha of A with each column of B,
   // masked to the active size, then narrowed to LARGURA bits.
   always_comb begin
      w_linha     = '0;
      w_ovf_linha = 1'b0;
      w_ea        = '0;
      w_eb        = '0;
      w_prod      = '0;
      w_acc       = '0;
      w_el        = '0;
      for (int j = 0; j < N_MAX; j++) begin
         w_acc = '0;
         for (int t = 0; t < N_MAX; t++) begin
            w_ea   = r_a[LARGURA*(t + N_MAX*int'(r_linha)) +: LARGURA];
            w_eb   = r_b[LARGURA*(j + N_MAX*t) +: LARGURA];
            w_prod = PW'(w_ea) * PW'(w_eb);
            if (TW'(t) < r_tam && TW'(j) < r_tam)
               w_acc = w_acc + AW'(w_prod);
         end
         if (w_acc > MAXV) begin
            w_ovf_linha = 1'b1;
            w_el = (SATURAR != 0) ? MAXV[LARGURA-1:0] : w_acc[LARGURA-1:0];
         end else if (w_acc < MINV) begin
            w_ovf_linha = 1'b1;
            w_el = (SATURAR != 0) ? MINV[LARGURA-1:0] : w_acc[LARGURA-1:0];
         end else begin
            w_el = w_acc[LARGURA-1:0];
         end
         w_linha[LARGURA*j +: LARGURA] = w_el;
      end
   end

   // Datapath: operand latch on accept, row write-back, status pulses and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_tam      <= '0;
         r_linha    <= '0;
         r_result   <= '0;
         r_ocupado  <= 1'b0;
         r_pronto   <= 1'b0;
         r_erro     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_pronto <= 1'b0;
         r_erro   <= 1'b0;
         if (w_aceita) begin
            r_a        <= bus.matriz_a;
            r_b        <= bus.matriz_b;
            r_tam      <= bus.tamanho;
            r_linha    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_ocupado  <= 1'b1;
         end
         if (w_rejeita)
            r_erro <= 1'b1;
         if (r_estado == CALCULA) begin
            r_result[RW*int'(r_linha) +: RW] <= w_linha;
            r_overflow <= r_overflow | w_ovf_linha;
            if (w_fim) begin
               r_pronto  <= 1'b1;
               r_ocupado <= 1'b0;
            end else begin
               r_linha <= r_linha + TW'(1);
            end
         end
      end
   end

   assign bus.matriz_result = r_result;
   assign bus.ocupado       = r_ocupado;
   assign bus.pronto        = r_pronto;
   assign bus.erro          = r_erro;
   assign bus.overflow      = r_overflow;
   assign o_dbg_estado      = (r_estado == CALCULA);

endmodule

// File: tb/tb_multiplicador_matrizes_param.sv
// Directed bench for the matrix multiplier: one saturating and one wrapping
// instance share the same stimulus; expectations are hand-derived constants.
module tb_multiplicador_matrizes_param;
   localparam int N  = 5;
   localparam int L  = 8;
   localparam int TW = $clog2(N + 1);
   localparam int MW = N * N * L;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dbg_s, dbg_w;

   logic          drv_inicio = 1'b0;
   logic [TW-1:0] drv_tam    = '0;
   logic [MW-1:0] drv_a      = '0;
   logic [MW-1:0] drv_b      = '0;

   int n_total = 0;
   int n_bad   = 0;
   int n_pronto = 0;
   int lat;
   int snap;
   int e  [N][N];
   int ew [N][N];
   logic [MW-1:0] a_saved;

   multiplicador_matrizes_param_if #(.N_MAX(N), .LARGURA(L)) bus_s ();
   multiplicador_matrizes_param_if #(.N_MAX(N), .LARGURA(L)) bus_w ();

   assign bus_s.inicio = drv_inicio;
   assign bus_s.tamanho = drv_tam;
   assign bus_s.matriz_a = drv_a;
   assign bus_s.matriz_b = drv_b;
   assign bus_w.inicio = drv_inicio;
   assign bus_w.tamanho = drv_tam;
   assign bus_w.matriz_a = drv_a;
   assign bus_w.matriz_b = drv_b;

   multiplicador_matrizes_param #(.N_MAX(N), .LARGURA(L), .SATURAR(1)) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s.slave), .o_dbg_estado(dbg_s));
   multiplicador_matrizes_param #(.N_MAX(N), .LARGURA(L), .SATURAR(0)) dut_w (
      .clk(clk), .rst(rst), .bus(bus_w.slave), .o_dbg_estado(dbg_w));

   // clock / reset
   always #5 clk = ~clk;

   always @(negedge clk) if (bus_s.pronto === 1'b1) n_pronto++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // helpers
   function automatic logic [MW-1:0] put(input logic [MW-1:0] v, input int i, input int j, input int val);
      v[L*(j + N*i) +: L] = L'(val);
      return v;
   endfunction

   function automatic int get(input logic [MW-1:0] v, input int i, input int j);
      logic signed [L-1:0] x;
      x = v[L*(j + N*i) +: L];
      return int'(x);
   endfunction

   function automatic logic [MW-1:0] fill(input int val);
      logic [MW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) v = put(v, i, j, val);
      return v;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_mat(input string tag, input logic [MW-1:0] res, input int ex [N][N]);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("%s(%0d,%0d)", tag, i, j), get(res, i, j), ex[i][j]);
   endtask

   task automatic set_box(input int tam, input int val_s, input int val_w);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            e[i][j]  = (i < tam && j < tam) ? val_s : 0;
            ew[i][j] = (i < tam && j < tam) ? val_w : 0;
         end
   endtask

   // driver: issue a start, then wait (bounded) for pronto; lat = edges after the start edge
   task automatic run_op(input string tag, input int tam);
      drv_inicio = 1'b1;
      drv_tam    = TW'(tam);
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      chk({tag, "_ocupado_start"}, bus_s.ocupado, 1);
      lat = 0;
      while (bus_s.pronto !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, tam);
      chk({tag, "_ocupado_done"}, bus_s.ocupado, 0);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", (bus_s.matriz_result == '0), 1);
      chk("rst_ocupado", bus_s.ocupado, 0);
      chk("rst_pronto", bus_s.pronto, 0);
      chk("rst_erro", bus_s.erro, 0);
      chk("rst_overflow", bus_s.overflow, 0);
      chk("rst_state", dbg_s, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // rejected sizes: 0 and N_MAX+1
      drv_inicio = 1'b1; drv_tam = 0;
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      chk("err0_erro", bus_s.erro, 1);
      chk("err0_ocupado", bus_s.ocupado, 0);
      @(posedge clk); #1;
      chk("err0_erro_drop", bus_s.erro, 0);
      drv_inicio = 1'b1; drv_tam = 6;
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      chk("err6_erro", bus_s.erro, 1);
      chk("err6_ocupado", bus_s.ocupado, 0);
      chk("err6_state", dbg_s, 0);
      @(posedge clk); #1;
      chk("err6_erro_drop", bus_s.erro, 0);

      // identity: R == A
      drv_a = '0; drv_b = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) drv_a = put(drv_a, i, j, int'($urandom_range(22)) - 11);
         drv_b = put(drv_b, i, i, 1);
      end
      a_saved = drv_a;
      run_op("ident", 5);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) e[i][j] = get(a_saved, i, j);
      chk_mat("ident_s", bus_s.matriz_result, e);
      chk_mat("ident_w", bus_w.matriz_result, e);
      chk("ident_ovf", bus_s.overflow, 0);
      @(posedge clk); #1;
      chk("ident_pronto_drop", bus_s.pronto, 0);

      // signed: A(i,j)=i-j, B(i,j)=i+j; R(i,j) = 10i + 5ij - 30 - 10j
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            drv_a = put(drv_a, i, j, i - j);
            drv_b = put(drv_b, i, j, i + j);
            e[i][j] = 10*i + 5*i*j - 30 - 10*j;
         end
      run_op("signed", 5);
      chk_mat("signed_s", bus_s.matriz_result, e);
      chk_mat("signed_w", bus_w.matriz_result, e);
      chk("signed_ovf", bus_s.overflow, 0);

      // reduced size: tam=3, all 2 -> 12 inside, 0 outside
      drv_a = fill(2); drv_b = fill(2);
      run_op("reduced", 3);
      set_box(3, 12, 12);
      chk_mat("reduced_s", bus_s.matriz_result, e);
      chk("reduced_ovf", bus_s.overflow, 0);

      // positive overflow: 2*100*100 = 20000 -> 127 / 32
      drv_a = fill(100); drv_b = fill(100);
      run_op("satpos", 2);
      set_box(2, 127, 32);
      chk_mat("satpos_s", bus_s.matriz_result, e);
      chk_mat("satpos_w", bus_w.matriz_result, ew);
      chk("satpos_ovf_s", bus_s.overflow, 1);
      chk("satpos_ovf_w", bus_w.overflow, 1);

      // negative overflow: -20000 -> -128 / -32
      drv_b = fill(-100);
      run_op("satneg", 2);
      set_box(2, -128, -32);
      chk_mat("satneg_s", bus_s.matriz_result, e);
      chk_mat("satneg_w", bus_w.matriz_result, ew);
      chk("satneg_ovf_s", bus_s.overflow, 1);
      chk("satneg_ovf_w", bus_w.overflow, 1);

      // exact upper limit, tam=1, outer elements non-zero but masked
      drv_a = fill(127); drv_b = fill(1);
      run_op("max1", 1);
      set_box(1, 127, 127);
      chk_mat("max1_s", bus_s.matriz_result, e);
      chk("max1_ovf_cleared", bus_s.overflow, 0);

      // exact lower limit
      drv_a = fill(-128);
      run_op("min1", 1);
      set_box(1, -128, -128);
      chk_mat("min1_w", bus_w.matriz_result, e);
      chk("min1_ovf", bus_w.overflow, 0);

      // second request while busy is ignored
      drv_a = fill(1); drv_b = fill(1);
      drv_inicio = 1'b1; drv_tam = 4;
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      @(posedge clk); #1;
      drv_a = fill(3); drv_b = fill(3); drv_tam = 2; drv_inicio = 1'b1;
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      chk("busy_erro", bus_s.erro, 0);
      lat = 2;
      while (bus_s.pronto !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("busy_latency", lat, 4);
      set_box(4, 4, 4);
      chk_mat("busy_s", bus_s.matriz_result, e);

      // inicio held high: restart in the cycle after pronto
      drv_a = fill(1); drv_b = fill(1);
      @(posedge clk); #1;
      drv_inicio = 1'b1; drv_tam = 2;
      @(posedge clk); #1;
      lat = 0;
      while (bus_s.pronto !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_latency", lat, 2);
      chk("b2b_first_r00", get(bus_s.matriz_result, 0, 0), 2);
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      chk("b2b_restart_ocupado", bus_s.ocupado, 1);
      chk("b2b_restart_cleared", get(bus_s.matriz_result, 0, 0), 0);
      lat = 0;
      while (bus_s.pronto !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_second_latency", lat, 2);
      set_box(2, 2, 2);
      chk_mat("b2b_s", bus_s.matriz_result, e);

      // asynchronous reset mid-operation
      @(posedge clk); #1;
      snap = n_pronto;
      drv_inicio = 1'b1; drv_tam = 5;
      @(posedge clk); #1;
      drv_inicio = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_result", (bus_s.matriz_result == '0), 1);
      chk("abort_ocupado", bus_s.ocupado, 0);
      chk("abort_state", dbg_s, 0);
      repeat (6) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_pronto", n_pronto, snap);
      chk("abort_result_held", (bus_s.matriz_result == '0), 1);
      drv_a = fill(-3); drv_b = fill(5);
      run_op("after_rst", 2);
      set_box(2, -30, -30);
      chk_mat("after_rst_s", bus_s.matriz_result, e);
      chk("after_rst_ovf", bus_s.overflow, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
